// File: rtl/time_setter_pkg.sv
// Shared encodings for the time setter: FSM states, cursor positions and BCD digit limits.
package time_setter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [2:0] CUR_HOUR10   = 3'd0;
  localparam logic [2:0] CUR_HOUR1    = 3'd1;
  localparam logic [2:0] CUR_MINUTE10 = 3'd2;
  localparam logic [2:0] CUR_MINUTE1  = 3'd3;
  localparam logic [2:0] CUR_SECOND10 = 3'd4;
  localparam logic [2:0] CUR_SECOND1  = 3'd5;

  localparam logic [3:0] LIM_HOUR10   = 4'd2;
  localparam logic [3:0] LIM_NINE     = 4'd9;
  localparam logic [3:0] LIM_HOUR1_20 = 4'd3;
  localparam logic [3:0] LIM_TENS     = 4'd5;

  // Upper bound of the digit at idx; hour1 depends on the current hour10.
  function automatic logic [3:0] digit_limit(input logic [2:0] idx, input logic [3:0] hour10);
    logic [3:0] lim;
    case (idx)
      CUR_HOUR10:   lim = LIM_HOUR10;
      CUR_HOUR1:    lim = (hour10 == LIM_HOUR10) ? LIM_HOUR1_20 : LIM_NINE;
      CUR_MINUTE10: lim = LIM_TENS;
      CUR_SECOND10: lim = LIM_TENS;
      default:      lim = LIM_NINE;
    endcase
    return lim;
  endfunction

endpackage

// File: rtl/time_setter_button_debounce.sv
// Two-flop synchronizer, stability-count debouncer and rising-edge press pulse.
// The debounced level flips only after DB_CYCLES consecutive samples that differ from it.
module button_debounce #(
  parameter int DB_CYCLES = 100000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);

  logic [1:0]    sync;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync    <= 2'b00;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync    <= {sync[0], raw};
      level_q <= level;
      // Any sample agreeing with the current level restarts the stability window.
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = level & ~level_q;

endmodule

// File: rtl/time_setter.sv
// Pushbutton-driven BCD time editor: load current time, edit digit by digit, commit with a one-cycle write.
// Button presses are debounced; mode outranks next, which outranks up/down.
module time_setter
  import time_setter_pkg::*;
#(
  parameter int DB_CYCLES = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [3:0] curHour10,
  input  logic [3:0] curHour1,
  input  logic [3:0] curMinute10,
  input  logic [3:0] curMinute1,
  input  logic [3:0] curSecond10,
  input  logic [3:0] curSecond1,
  output logic [3:0] setHour10,
  output logic [3:0] setHour1,
  output logic [3:0] setMinute10,
  output logic [3:0] setMinute1,
  output logic [3:0] setSecond10,
  output logic [3:0] setSecond1,
  output logic       write,
  output logic       editing,
  output logic [2:0] cursor
);

  logic p_mode, p_next, p_up, p_down;

  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (.clock(clock), .reset(reset), .raw(btn_mode), .press(p_mode));
  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_next (.clock(clock), .reset(reset), .raw(btn_next), .press(p_next));
  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up   (.clock(clock), .reset(reset), .raw(btn_up),   .press(p_up));
  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_down (.clock(clock), .reset(reset), .raw(btn_down), .press(p_down));

  state_t          state_q, state_n;
  logic [5:0][3:0] dig_q, dig_n;
  logic [2:0]      cursor_q, cursor_n;
  logic [3:0]      sel, lim, nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      dig_q    <= '0;
      cursor_q <= CUR_HOUR10;
      editing  <= 1'b0;
      write    <= 1'b0;
    end else begin
      state_q  <= state_n;
      dig_q    <= dig_n;
      cursor_q <= cursor_n;
      editing  <= (state_n == EDIT);
      write    <= (state_n == COMMIT);
    end
  end

  always_comb begin
    state_n  = state_q;
    dig_n    = dig_q;
    cursor_n = cursor_q;
    sel      = dig_q[cursor_q];
    lim      = digit_limit(cursor_q, dig_q[CUR_HOUR10]);
    nxt      = sel;
    case (state_q)
      IDLE: begin
        if (p_mode) begin
          state_n  = EDIT;
          dig_n    = {curSecond1, curSecond10, curMinute1, curMinute10, curHour1, curHour10};
          cursor_n = CUR_HOUR10;
        end
      end
      EDIT: begin
        if (p_mode) begin
          state_n = COMMIT;
        end else if (p_next) begin
          cursor_n = (cursor_q == CUR_SECOND1) ? CUR_HOUR10 : cursor_q + 3'd1;
        end else if (p_up ^ p_down) begin
          if (p_up) nxt = (sel >= lim) ? 4'd0 : sel + 4'd1;
          else      nxt = (sel == 4'd0) ? lim : sel - 4'd1;
          dig_n[cursor_q] = nxt;
          // Keep the hour within 23 when hour10 lands on 2.
          if (dig_n[CUR_HOUR10] == LIM_HOUR10 && dig_n[CUR_HOUR1] > LIM_HOUR1_20)
            dig_n[CUR_HOUR1] = LIM_HOUR1_20;
        end
      end
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign cursor      = cursor_q;
  assign setHour10   = dig_q[CUR_HOUR10];
  assign setHour1    = dig_q[CUR_HOUR1];
  assign setMinute10 = dig_q[CUR_MINUTE10];
  assign setMinute1  = dig_q[CUR_MINUTE1];
  assign setSecond10 = dig_q[CUR_SECOND10];
  assign setSecond1  = dig_q[CUR_SECOND1];

endmodule
